// File: rtl/x_counter_ctrl.sv
// x_counter_ctrl: timer controller that sequences a WIDTH-bit up-counter.
// The host controls it with start, stop and clear commands. It also provides
// a programmable prescaler, a terminal period, and one-shot or periodic mode.
//
// Ports:
//   i_clk, i_rst           clock; asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready command handshake; ready is registered and
//                           drops for one cycle after every accept
//   i_cmd, i_cmd_data       opcode and payload
//   o_count                 current count
//   o_running, o_done       state flags (RUN, DONE)
//   o_expire                one-cycle pulse after a terminal step
module x_counter_ctrl #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_done,
  output logic             o_expire
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [2:0] CMD_START    = 3'd0;
  localparam logic [2:0] CMD_STOP     = 3'd1;
  localparam logic [2:0] CMD_CLEAR    = 3'd2;
  localparam logic [2:0] CMD_LD_PER   = 3'd3;
  localparam logic [2:0] CMD_LD_PRE   = 3'd4;
  localparam logic [2:0] CMD_LD_CNT   = 3'd5;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             mode_q, mode_d;       // 1 = periodic
  logic             expire_q, expire_d;
  logic             ready_q, ready_d;
  logic             accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '1;
      pre_q      <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      expire_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      expire_q   <= expire_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    pre_d      = pre_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    expire_d   = 1'b0;
    accept     = i_cmd_valid & ready_q;
    // Ready goes low for the cycle after an accept, so accepts happen at most every other cycle.
    ready_d    = ~accept;

    if (accept) begin
      // A command cycle replaces the step: only the command's own effect lands.
      case (i_cmd)
        CMD_START: begin
          mode_d = i_cmd_data[0];
          case (state_q)
            IDLE, PAUSE: state_d = RUN;        // resume, keep count/pre_q
            DONE: begin
              state_d = RUN;
              count_d = '0;
              pre_d   = '0;
            end
            default: ;                         // already running: mode only
          endcase
        end
        CMD_STOP: if (state_q == RUN) state_d = PAUSE;
        CMD_CLEAR: begin
          state_d = IDLE;
          count_d = '0;
          pre_d   = '0;
        end
        CMD_LD_PER: period_d   = i_cmd_data;
        CMD_LD_PRE: prescale_d = i_cmd_data[PRE_W-1:0];
        CMD_LD_CNT: if (state_q == IDLE || state_q == PAUSE) count_d = i_cmd_data;
        default: ;
      endcase
    end else if (state_q == RUN) begin
      if (pre_q == prescale_q) begin
        pre_d = '0;
        // The >= test also catches a period lowered below the count.
        // It also means count+1 can never wrap.
        if (count_q >= period_q) begin
          expire_d = 1'b1;
          if (mode_q) count_d = '0;
          else        state_d = DONE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_count     = count_q;
  assign o_running   = (state_q == RUN);
  assign o_done      = (state_q == DONE);
  assign o_expire    = expire_q;

endmodule

// File: tb/tb_x_counter_ctrl.sv
// Self-checking bench for x_counter_ctrl: directed scenarios plus random
// command traffic, all compared each cycle against a behavioural model.
module tb_x_counter_ctrl;
  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [2:0]   i_cmd;
  logic [W-1:0] i_cmd_data;
  logic [W-1:0] o_count;
  logic         o_running, o_done, o_expire;

  always #5 i_clk = ~i_clk;

  x_counter_ctrl #(.WIDTH(W), .PRE_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_cmd(i_cmd), .i_cmd_data(i_cmd_data),
    .o_count(o_count), .o_running(o_running), .o_done(o_done),
    .o_expire(o_expire)
  );

  int errs = 0;
  int checks = 0;
  int exp_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer described as mode flags and a tick divider.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int           m_state;
  logic [W-1:0] m_count, m_period;
  logic [7:0]   m_div, m_prescale;
  bit           m_periodic, m_expire, m_ready;

  task automatic model_reset();
    m_state = M_IDLE; m_count = '0; m_period = '1; m_div = '0;
    m_prescale = '0; m_periodic = 0; m_expire = 0; m_ready = 1;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] c, input logic [W-1:0] d);
    bit took;
    took = v && m_ready;
    m_ready = !took;
    m_expire = 0;
    if (took) begin
      if (c == 0) begin
        m_periodic = d[0];
        if (m_state == M_DONE) begin m_count = 0; m_div = 0; end
        m_state = M_RUN;
      end else if (c == 1) begin
        if (m_state == M_RUN) m_state = M_PAUSE;
      end else if (c == 2) begin
        m_state = M_IDLE; m_count = 0; m_div = 0;
      end else if (c == 3) m_period = d;
      else if (c == 4) m_prescale = d[7:0];
      else if (c == 5) begin
        if (m_state == M_IDLE || m_state == M_PAUSE) m_count = d;
      end
    end else if (m_state == M_RUN) begin
      if (m_div != m_prescale) m_div++;
      else begin
        m_div = 0;
        if (m_count < m_period) m_count++;
        else begin
          m_expire = 1;
          if (m_periodic) m_count = 0; else m_state = M_DONE;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("count",   o_count,     m_count);
    chk("running", o_running,   m_state == M_RUN);
    chk("done",    o_done,      m_state == M_DONE);
    chk("expire",  o_expire,    m_expire);
    chk("ready",   o_cmd_ready, m_ready);
  endtask

  // One clock: drive inputs, advance the model at the edge, and check 1ns after the edge.
  task automatic tick(input bit v, input logic [2:0] c, input logic [W-1:0] d);
    i_cmd_valid = v; i_cmd = c; i_cmd_data = d;
    @(posedge i_clk);
    model_edge(v, c, d);
    #1;
    check_outs();
    if (o_expire) exp_seen++;
  endtask

  task automatic send(input logic [2:0] c, input logic [W-1:0] d);
    bit was;
    int n = 0;
    do begin
      was = m_ready;
      tick(1, c, d);
      n++;
    end while (!was && n < 4);
    chk("send_accept", was, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 3'd7, '0);
  endtask

  task automatic run_until(input logic [W-1:0] target, input int budget);
    int n = 0;
    while (o_count != target && n < budget) begin tick(0, 3'd7, '0); n++; end
    chk("reach_count", o_count, target);
  endtask

  task automatic do_reset();
    i_cmd_valid = 0;
    #2 i_rst = 1;
    #1;
    model_reset();
    check_outs();
    chk("rst_count0", o_count, 0);
    @(posedge i_clk);
    #1 i_rst = 0;
  endtask

  initial begin
    bit cur_v, last_acc;
    logic [2:0] cur_c;
    logic [W-1:0] cur_d;

    i_rst = 1; i_cmd_valid = 0; i_cmd = '0; i_cmd_data = '0;
    model_reset();
    #1;
    check_outs();
    @(posedge i_clk);
    #1 i_rst = 0;

    // 1: periodic, period 3, prescale 0
    send(3, 3); send(4, 0); send(0, 1);
    exp_seen = 0;
    idle(12);
    chk("t1_expires", exp_seen, 3);

    // 2: one-shot, period 2, prescale 1
    do_reset();
    send(3, 2); send(4, 1); send(0, 0);
    exp_seen = 0;
    idle(10);
    chk("t2_done", o_done, 1);
    chk("t2_hold", o_count, 2);
    chk("t2_one_expire", exp_seen, 1);

    // 3: stop at 5, pause, resume
    do_reset();
    send(3, 20); send(4, 1); send(0, 0);
    run_until(5, 40);
    send(1, 0);
    idle(10);
    chk("t3_paused", o_count, 5);
    chk("t3_not_run", o_running, 0);
    send(0, 0);
    idle(2);
    chk("t3_resumed", o_count, 6);

    // 4: clear exactly when a terminal step is due
    do_reset();
    send(3, 2); send(4, 0); send(0, 0);
    run_until(2, 20);
    send(2, 0);
    chk("t4_no_expire", o_expire, 0);
    chk("t4_idle", o_count, 0);
    idle(3);

    // 5: valid held high across three queued commands
    send(3, 9); send(4, 0); send(0, 1);
    idle(4);

    // 6: top of range, then asynchronous reset mid-run
    do_reset();
    send(5, 32'hFFFF_FFFE); send(3, 32'hFFFF_FFFF); send(0, 1);
    chk("t6_a", o_count, 32'hFFFF_FFFE);
    idle(1);
    chk("t6_b", o_count, 32'hFFFF_FFFF);
    idle(1);
    chk("t6_wrap", o_count, 0);
    chk("t6_expire", o_expire, 1);
    idle(3);
    do_reset();
    send(5, 32'hFFFF_FFFD); send(0, 1);
    exp_seen = 0;
    idle(5);
    chk("t6_period_reset", exp_seen, 1);

    // Random traffic
    cur_v = 0; cur_c = 0; cur_d = 0; last_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset();
        cur_v = 0;
      end
      if (!(cur_v && !last_acc)) begin
        cur_v = ($urandom_range(0, 2) == 0);
        cur_c = 3'($urandom_range(0, 7));
        case (cur_c)
          3'd3: cur_d = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(0, 7));
          3'd4: cur_d = W'($urandom_range(0, 2));
          3'd5: cur_d = W'($urandom_range(0, 10));
          default: cur_d = W'($urandom);
        endcase
      end
      last_acc = cur_v && m_ready;
      tick(cur_v, cur_c, cur_d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
